cp0_int_sequencer: RTL and testbench

//  Front end for the six CP0 hardware interrupt lines: synchronises and deglitches the raw lines.

---
 rtl/cp0_int_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cp0_int_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_int_sequencer.sv
// cp0_int_sequencer: sync + deglitch of the CP0 hardware interrupt pins, and
// scheduling of interrupt takes at a safe M-stage point.
//   in : clk, rst (async, active-low), int_raw, im_i, int_en_i,
//        validM, stallM, flush_exception_i
//   out: int_o (filtered), int_pending_o, int_id_o, int_take_o,
//        int_taken_id_o, busy_o
module cp0_int_sequencer #(
  parameter int NUM_INT        = 6,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] int_raw,
  input  logic [NUM_INT-1:0] im_i,
  input  logic               int_en_i,
  input  logic               validM,
  input  logic               stallM,
  input  logic               flush_exception_i,
  output logic [NUM_INT-1:0] int_o,
  output logic               int_pending_o,
  output logic [2:0]         int_id_o,
  output logic               int_take_o,
  output logic [2:0]         int_taken_id_o,
  output logic               busy_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 2);

  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_HOLD
  } state_t;

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0][NUM_INT-1:0] sync_q;
  logic [SYNC_STAGES-1:0][NUM_INT-1:0] sync_d;
  logic [NUM_INT-1:0]                  s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], int_raw};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // ---------------- deglitch filter ----------------
  // A line only flips once the synchronised value has disagreed with the
  // filtered level for FILTER_LEN consecutive samples.
  logic [NUM_INT-1:0][CW-1:0] cnt_q;
  logic [NUM_INT-1:0][CW-1:0] cnt_d;
  logic [NUM_INT-1:0]         filt_q;
  logic [NUM_INT-1:0]         filt_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < NUM_INT; i++) begin
      if (s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign int_o = filt_q;

  // ---------------- priority ----------------
  logic [NUM_INT-1:0] act;
  logic [2:0]         id_c;

  assign act           = filt_q & im_i;
  assign int_pending_o = |act;

  // Ascending scan: the highest active index is the last one written.
  always_comb begin
    id_c = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (act[i]) begin
        id_c = 3'(i);
      end
    end
  end

  assign int_id_o = id_c;

  // ---------------- take scheduler ----------------
  state_t          state_q;
  logic [HW-1:0]   hold_q;
  logic [2:0]      taken_q;
  logic            want;
  logic            safe;

  assign want = int_pending_o & int_en_i;
  assign safe = validM & ~stallM & ~flush_exception_i;

  // Mealy pulse: the take lands on the instruction sitting in M right now.
  assign int_take_o     = (state_q == S_ARMED) & want & safe;
  assign int_taken_id_o = taken_q;
  assign busy_o         = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      taken_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (want) begin
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!want) begin
            state_q <= S_IDLE;
          end else if (safe) begin
            taken_q <= id_c;
            if (HOLDOFF_CYCLES == 0) begin
              state_q <= S_IDLE;
            end else begin
              hold_q  <= HOLD_LD;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_int_sequencer.sv
// tb_cp0_int_sequencer: directed + random stimulus against a
// history-based reference model of the interrupt sequencer.
module tb_cp0_int_sequencer;

  localparam int N    = 6;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int HOLD = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] im;
  logic         en;
  logic         vm;
  logic         sm;
  logic         fl;
  logic [N-1:0] int_o;
  logic         int_pending_o;
  logic [2:0]   int_id_o;
  logic         int_take_o;
  logic [2:0]   int_taken_id_o;
  logic         busy_o;

  cp0_int_sequencer #(
    .NUM_INT(N),
    .SYNC_STAGES(SYNC),
    .FILTER_LEN(FILT),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .int_raw(raw),
    .im_i(im),
    .int_en_i(en),
    .validM(vm),
    .stallM(sm),
    .flush_exception_i(fl),
    .int_o(int_o),
    .int_pending_o(int_pending_o),
    .int_id_o(int_id_o),
    .int_take_o(int_take_o),
    .int_taken_id_o(int_taken_id_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [N-1:0] rq[$];
  logic [N-1:0] sw[$];
  logic [N-1:0] mo;
  bit           m_armed;
  int           last_take;
  int           cyc;
  logic [2:0]   m_tid;
  logic         tk;

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    sw.delete();
    for (int k = 0; k < SYNC; k++) rq.push_back('0);
    for (int k = 0; k < FILT; k++) sw.push_back('0);
    mo        = '0;
    m_armed   = 0;
    last_take = -1000;
    cyc       = 0;
    m_tid     = '0;
  endtask

  // One clock: compare mid-low-phase, then advance the model on the edge.
  task automatic step();
    logic [N-1:0] a;
    logic [N-1:0] s;
    logic [2:0]   id;
    logic         pend, want, safe, hold, tm, bz, found, all;
    #2;
    if (!rst) model_reset();
    a     = mo & im;
    pend  = |a;
    id    = '0;
    found = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i] && !found) begin
        id    = 3'(i);
        found = 1;
      end
    end
    want = pend & en;
    safe = vm & ~sm & ~fl;
    hold = (cyc - last_take >= 1) && (cyc - last_take <= HOLD);
    tm   = m_armed & want & safe;
    bz   = m_armed | hold;
    chk("int_o", 8'(int_o), 8'(mo));
    chk("pending", 8'(int_pending_o), 8'(pend));
    chk("int_id", 8'(int_id_o), 8'(id));
    chk("take", 8'(int_take_o), 8'(tm));
    chk("taken_id", 8'(int_taken_id_o), 8'(m_tid));
    chk("busy", 8'(busy_o), 8'(bz));
    tk = int_take_o;
    @(posedge clk);
    if (rst) begin
      s = rq.pop_front();
      rq.push_back(raw);
      void'(sw.pop_front());
      sw.push_back(s);
      for (int i = 0; i < N; i++) begin
        all = 1;
        foreach (sw[k]) if (sw[k][i] == mo[i]) all = 0;
        if (all) mo[i] = ~mo[i];
      end
      if (tm) begin
        m_tid     = id;
        last_take = cyc;
      end
      m_armed = want && !hold && !tm;
      cyc++;
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  initial begin
    int lat, f1, f2, n;
    logic seen;
    rst = 0; raw = '0; im = '0; en = 0; vm = 0; sm = 0; fl = 0;
    tk  = 0;
    model_reset();
    @(negedge clk);

    // T1: reset holds everything low, then 6-cycle rise after release
    for (int k = 0; k < 4; k++) begin
      raw = 6'($urandom);
      im  = '1;
      en  = 1;
      step();
    end
    chk("t1_rst_outs", {int_pending_o, busy_o, int_o}, 8'h00);
    rst = 1; raw = 6'h3f; im = '0; en = 0;
    for (int k = 0; k < 5; k++) step();
    chk("t1_hold", 8'(int_o), 8'h00);
    step();
    chk("t1_rise", 8'(int_o), 8'h3f);

    // T2: short glitch rejected, long pulse passes with 6-cycle latency
    raw = '0;
    for (int k = 0; k < 8; k++) step();
    raw[2] = 1;
    for (int k = 0; k < 3; k++) step();
    raw  = '0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen |= int_o[2];
    end
    chk("t2_glitch", 8'(seen), 8'h00);
    raw[2] = 1;
    lat = 99;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (int_o[2] && lat == 99) lat = k;
    end
    chk("t2_lat", 8'(lat), 8'd6);

    // T3: take with holdoff spacing
    raw = 6'h01; im = 6'h01; en = 1; vm = 1; sm = 0; fl = 0;
    f1 = -1; f2 = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tk) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
      end
    end
    chk("t3_first", 8'(f1), 8'd8);
    chk("t3_gap", 8'(f2 - f1), 8'd4);
    chk("t3_tid", 8'(int_taken_id_o), 8'd0);

    // T4: stall defers the take to the first unstalled cycle
    en = 0;
    for (int k = 0; k < 3; k++) step();
    en = 1; sm = 1; n = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      n += int'(tk);
    end
    chk("t4_stall", 8'(n), 8'd0);
    sm = 0;
    step();
    chk("t4_take", 8'(tk), 8'd1);

    // T5: priority under mask, then withdrawal by masking
    raw = 6'b100101; im = 6'b000101; en = 0;
    for (int k = 0; k < 8; k++) step();
    chk("t5_id", 8'(int_id_o), 8'd2);
    chk("t5_pend", 8'(int_pending_o), 8'd1);
    en = 1; sm = 1;
    step();
    step();
    chk("t5_armed", 8'(busy_o), 8'd1);
    im = '0;
    step();
    chk("t5_notake", 8'(tk), 8'd0);
    chk("t5_pend0", 8'(int_pending_o), 8'd0);
    chk("t5_idle", 8'(busy_o), 8'd0);

    // T6: exception flush beats the take for one cycle
    im = 6'b000101; sm = 1;
    step();
    step();
    sm = 0; fl = 1; vm = 1;
    step();
    chk("t6_flush", 8'(tk), 8'd0);
    fl = 0;
    step();
    chk("t6_take", 8'(tk), 8'd1);
    chk("t6_tid", 8'(int_taken_id_o), 8'd2);

    // random phase
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(9) == 0) raw[i] = ~raw[i];
      if ($urandom_range(19) == 0) im = 6'($urandom);
      en  = ($urandom_range(9) != 0);
      vm  = ($urandom_range(3) != 0);
      sm  = ($urandom_range(3) == 0);
      fl  = ($urandom_range(9) == 0);
      rst = ($urandom_range(499) != 0);
      step();
    end
    rst = 1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
